// File: rtl/fact_sequencer.sv
// Factorial accelerator register-protocol sequencer: accepts n, writes n and a Go pulse,
// polls status, reads the result and returns it. Optional poll timeout: FACT_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// WR_N   | writing operand to addr 0
// WR_GO  | writing Go=1 to addr 1
// CLR_GO | writing Go=0 to addr 1
// POLL   | reading status at addr 2 until err/done
// RD_RES | reading result at addr 3
// RESP   | holding the response until rsp_ready
module fact_sequencer #(
  parameter int unsigned N_MAX = 12
`ifdef FACT_SEQ_TIMEOUT_EN
  , parameter int unsigned POLL_LIMIT = 255
`endif
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_n_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        busy_o,
  output logic [1:0]  fact_addr_o,
  output logic        fact_we_o,
  output logic [3:0]  fact_wd_o,
  input  logic [31:0] fact_rd_i
);

  typedef enum logic [2:0] {
    IDLE, WR_N, WR_GO, CLR_GO, POLL, RD_RES, RESP
  } state_e;

  localparam logic [3:0] NMaxW = 4'(N_MAX);

  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic        to_q, to_d;

`ifdef FACT_SEQ_TIMEOUT_EN
  localparam logic [7:0] PollLimW = 8'(POLL_LIMIT);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    result_d = result_q;
    err_d    = err_q;
    to_d     = to_q;
`ifdef FACT_SEQ_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          n_d      = req_n_i;
          result_d = 32'd0;
          to_d     = 1'b0;
          if (req_n_i > NMaxW) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = WR_N;
          end
        end
      end
      WR_N:   state_d = WR_GO;
      WR_GO:  state_d = CLR_GO;
      CLR_GO: begin
        state_d = POLL;
`ifdef FACT_SEQ_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      POLL: begin
        // err outranks done, and both outrank the timeout
        if (fact_rd_i[1]) begin
          err_d    = 1'b1;
          result_d = 32'd0;
          state_d  = RESP;
        end else if (fact_rd_i[0]) begin
          state_d = RD_RES;
        end
`ifdef FACT_SEQ_TIMEOUT_EN
        else if (cnt_q + 8'd1 == PollLimW) begin
          err_d    = 1'b1;
          to_d     = 1'b1;
          result_d = 32'd0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RD_RES: begin
        result_d = fact_rd_i;
        err_d    = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      n_q          <= 4'd0;
      result_q     <= 32'd0;
      err_q        <= 1'b0;
      to_q         <= 1'b0;
      req_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      fact_addr_o  <= 2'd0;
      fact_we_o    <= 1'b0;
      fact_wd_o    <= 4'd0;
`ifdef FACT_SEQ_TIMEOUT_EN
      cnt_q        <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      result_q    <= result_d;
      err_q       <= err_d;
      to_q        <= to_d;
      req_ready_o <= (state_d == IDLE);
      rsp_valid_o <= (state_d == RESP);
      busy_o      <= (state_d != IDLE);
      fact_we_o   <= (state_d == WR_N) || (state_d == WR_GO) || (state_d == CLR_GO);
      unique case (state_d)
        WR_N:          fact_addr_o <= 2'd0;
        WR_GO, CLR_GO: fact_addr_o <= 2'd1;
        POLL:          fact_addr_o <= 2'd2;
        RD_RES:        fact_addr_o <= 2'd3;
        default:       fact_addr_o <= 2'd0;
      endcase
      unique case (state_d)
        WR_N:    fact_wd_o <= n_d;
        WR_GO:   fact_wd_o <= 4'b0001;
        default: fact_wd_o <= 4'b0000;
      endcase
`ifdef FACT_SEQ_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  assign rsp_result_o = result_q;
  assign rsp_err_o    = err_q;
`ifdef FACT_SEQ_TIMEOUT_EN
  assign rsp_timeout_o = to_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fact_sequencer.sv
// Directed bench for fact_sequencer with a behavioural accelerator model and a response scoreboard.
module tb_fact_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_n = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [1:0]  fact_addr;
  logic        fact_we;
  logic [3:0]  fact_wd;
  logic [31:0] fact_rd;

  always #5 clk = ~clk;

  fact_sequencer #(
    .N_MAX(12)
`ifdef FACT_SEQ_TIMEOUT_EN
    , .POLL_LIMIT(8)
`endif
  ) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_n_i(req_n),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .fact_addr_o(fact_addr), .fact_we_o(fact_we), .fact_wd_o(fact_wd), .fact_rd_i(fact_rd)
  );

  // accelerator model
  logic [3:0] m_n = 4'd0;
  logic       m_done = 1'b0, m_err = 1'b0, m_pend = 1'b0;
  int         m_cnt = 0;
  int         m_dly = 0;
  bit         m_hang = 0, m_errmode = 0;
  logic [5:0] wr_log[$];
  int         rd3_cnt = 0;

  function automatic logic [31:0] fact_f(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (fact_we) wr_log.push_back({fact_addr, fact_wd});
    if (fact_we && fact_addr == 2'd0) m_n <= fact_wd;
    if (fact_we && fact_addr == 2'd1 && fact_wd[0]) begin
      m_pend <= 1'b1; m_cnt <= m_dly; m_done <= 1'b0; m_err <= 1'b0;
    end else if (m_pend && !m_hang) begin
      if (m_cnt == 0) begin
        m_pend <= 1'b0; m_done <= 1'b1; m_err <= m_errmode;
      end else m_cnt <= m_cnt - 1;
    end
  end

  always_comb begin
    fact_rd = 32'd0;
    case (fact_addr)
      2'd0: fact_rd = {28'd0, m_n};
      2'd2: fact_rd = {30'd0, m_err, m_done};
      2'd3: fact_rd = fact_f(m_n);
      default: fact_rd = 32'd0;
    endcase
  end

  always @(negedge clk) if (fact_addr == 2'd3) rd3_cnt++;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic        to;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] r, input logic e, input logic t, input int l);
    exp_t x;
    x.res = r; x.err = e; x.to = t; x.lat = l;
    exp_q.push_back(x);
  endtask

  // called just after a negedge; returns just after the negedge of cycle E+1
  task automatic send(input logic [3:0] n);
    req_n = n;
    req_valid = 1'b1;
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input int hold);
    exp_t x;
    int lat = -1;
    for (int k = 1; k <= 300; k++) begin
      if (rsp_valid) begin lat = k; break; end
      @(negedge clk);
    end
    check("rsp_latency", 32'(lat), 32'(exp_q.size() > 0 ? exp_q[0].lat : -2));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = exp_q.pop_front();
    check("rsp_result", rsp_result, x.res);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, x.err});
    check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, x.to});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_result", rsp_result, x.res);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_rsp_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rsp_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_result"}, rsp_result, 32'd0);
    check({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_timeout"}, {31'd0, rsp_timeout}, 32'd0);
    check({tag, "_we"}, {31'd0, fact_we}, 32'd0);
    check({tag, "_addr"}, {30'd0, fact_addr}, 32'd0);
    check({tag, "_wd"}, {28'd0, fact_wd}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ready_hi, nrsp, found;
    bit clr;
    exp_t x;
    logic [5:0] w;

    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // n=5, done three cycles after Go
    m_dly = 3;
    wr_log.delete();
    push(32'h0000_0078, 1'b0, 1'b0, 9);
    send(4'd5);
    finish_rsp(0);
    check("wr_count_n5", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      w = wr_log[0]; check("wr0", {26'd0, w}, {26'd0, 2'd0, 4'd5});
      w = wr_log[1]; check("wr1", {26'd0, w}, {26'd0, 2'd1, 4'd1});
      w = wr_log[2]; check("wr2", {26'd0, w}, {26'd0, 2'd1, 4'd0});
    end
    m_dly = 0;

    // back-to-back n=0 then n=12 with rsp_ready held high
    push(32'h0000_0001, 1'b0, 1'b0, 6);
    push(32'h1C8C_FC00, 1'b0, 1'b0, 6);
    rsp_ready = 1'b1;
    req_n = 4'd0;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_n = 4'd12;
    ready_hi = 0; nrsp = 0; clr = 0;
    for (int i = 0; i < 60; i++) begin
      if (clr) begin req_valid = 1'b0; clr = 0; end
      if (req_ready) ready_hi++;
      if (req_ready && req_valid) clr = 1;
      if (rsp_valid) begin
        if (exp_q.size() > 0) begin
          x = exp_q.pop_front();
          check("b2b_result", rsp_result, x.res);
          check("b2b_err", {31'd0, rsp_err}, {31'd0, x.err});
        end
        nrsp++;
        if (nrsp == 2) break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_rsp_count", 32'(nrsp), 32'd2);
    check("b2b_ready_cycles", 32'(ready_hi), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_idle", {31'd0, busy}, 32'd0);

    // out-of-range n
    wr_log.delete();
    push(32'd0, 1'b1, 1'b0, 1);
    send(4'd13);
    finish_rsp(0);
    check("oor_no_writes", 32'(wr_log.size()), 32'd0);

    // held response
    push(32'h0000_13B0, 1'b0, 1'b0, 6);
    send(4'd7);
    finish_rsp(10);

    // err and done together
    m_errmode = 1;
    rd3_cnt = 0;
    push(32'd0, 1'b1, 1'b0, 5);
    send(4'd4);
    finish_rsp(0);
    check("err_no_rd3", 32'(rd3_cnt), 32'd0);
    m_errmode = 0;

`ifdef FACT_SEQ_TIMEOUT_EN
    m_hang = 1;
    push(32'd0, 1'b1, 1'b1, 12);
    send(4'd6);
    finish_rsp(0);
    m_hang = 0;
`endif

    // reset during POLL
    m_hang = 1;
    send(4'd9);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (fact_addr == 2'd2) begin found = 1; break; end
      @(negedge clk);
    end
    check("reached_poll", 32'(found), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    check("in_reset_valid", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    m_hang = 0;
    @(negedge clk);
    check("post_reset_ready", {31'd0, req_ready}, 32'd1);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    push(32'h0000_0006, 1'b0, 1'b0, 6);
    send(4'd3);
    finish_rsp(0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fact_sequencer.md
Name: fact_sequencer

Overview:
- Hardware sequencer that drives the factorial accelerator's 4-word register interface on behalf of a requester.
- Accepts an operand n over a valid/ready request port, then runs the full register protocol: write n, pulse Go, poll status, read result.
- Returns the result or error over a valid/ready response port.
- Sits between a requester (CPU-side wrapper or test master) and fact_top. Replaces software polling through the address-decoded bus.

Parameters:
- N_MAX, 12, largest n forwarded to the accelerator; 12! is the largest factorial that fits in 32 bits.
- POLL_LIMIT, 255, maximum POLL cycles before timeout. Used only when FACT_SEQ_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_n  input  4  factorial operand.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  32  n! on success, 0 on error.
- rsp_err  output  1  out-of-range n, or accelerator error bit set.
- rsp_timeout  output  1  poll limit exceeded. Tied 0 when the macro is absent.
- busy  output  1  state != IDLE.
- fact_addr  output  2  accelerator register address: 0=n, 1=Go, 2=status {err,done} in bits [1:0], 3=result.
- fact_we  output  1  accelerator write enable.
- fact_wd  output  4  accelerator write data.
- fact_rd  input  32  accelerator read data, combinational from fact_addr.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - rsp_result=0, rsp_err=0, rsp_timeout=0, rsp_valid=0.
  - fact_we=0, fact_addr=0, fact_wd=0, busy=0.
  - req_ready=1 once reset is released.
- Reset asserted mid-operation: outputs return to reset values immediately. Any in-flight request is dropped with no response.
- fact_addr, fact_we and fact_wd are Moore outputs decoded from state. They never depend combinationally on req_* or rsp_*.
- States:
  - IDLE: req_ready=1. On req_valid & req_ready, latch req_n.
    - If req_n > N_MAX: go to RESP with err=1, result=0. No accelerator writes occur.
    - Otherwise: go to WR_N.
  - WR_N: addr=0, we=1, wd=n. Next: WR_GO.
  - WR_GO: addr=1, we=1, wd=4'b0001. Next: CLR_GO.
  - CLR_GO: addr=1, we=1, wd=4'b0000 (Go is a one-cycle level pulse). Next: POLL.
  - POLL: addr=2, we=0. fact_rd[1:0] is sampled at every edge.
    - err=1 (has priority over done): go to RESP with err=1, result=0.
    - done=1 only: go to RD_RES.
    - Neither set: stay in POLL.
  - RD_RES: addr=3, we=0. Capture fact_rd into rsp_result, set err=0. Next: RESP.
  - RESP: rsp_valid=1, req_ready=0. rsp_result, rsp_err and rsp_timeout are held stable until the handshake. On rsp_ready, go to IDLE the next cycle.
- No request is accepted while busy, so at most one request is in flight.
- Back-to-back requests are allowed: req_ready rises in the cycle after the response handshake.
- Latency, with the request accepted at edge E and done seen at the first poll:
  - WR_N occupies cycle E+1, WR_GO E+2, CLR_GO E+3, POLL E+4, RD_RES E+5.
  - rsp_valid is high in cycle E+6.
  - Each extra poll cycle adds 1.
- Out-of-range n: rsp_valid is high in cycle E+1.
- rsp_valid is never asserted while reset=0.

Optional Feature:
- FACT_SEQ_TIMEOUT_EN defined:
  - An 8-bit poll counter clears on entry to POLL and increments each POLL cycle.
  - When the counter reaches POLL_LIMIT with neither done nor err set: go to RESP with rsp_timeout=1, rsp_err=1, rsp_result=0.
  - If err or done is seen on the same cycle the limit is reached, err/done takes precedence.
- FACT_SEQ_TIMEOUT_EN undefined:
  - No counter exists; POLL waits indefinitely.
  - rsp_timeout is constant 0.

Test Plan:
- req_n=5, accelerator model asserts done 3 cycles after the Go pulse → write sequence (0,5), (1,1), (1,0); rsp_result=0x00000078, rsp_err=0, rsp_valid high exactly 3 cycles later than the minimum latency.
- req_n=0, then req_n=12 back-to-back with rsp_ready=1 → results 0x00000001 then 0x1C8CFC00; req_ready high for exactly one cycle between the two requests.
- req_n=13 → rsp_valid in cycle E+1 with rsp_err=1, rsp_result=0; fact_we never asserted.
- req_n=7, rsp_ready held 0 for 10 cycles → rsp_valid, rsp_result=0x000013B0 stable; req_ready=0 and busy=1 throughout; IDLE one cycle after rsp_ready rises.
- Model sets err and done together in POLL → rsp_err=1, rsp_result=0, no read of addr 3. With FACT_SEQ_TIMEOUT_EN and POLL_LIMIT=8 and a model that never sets done → rsp_timeout=1 after 8 POLL cycles.
- reset driven low during POLL for n=9 → all outputs return to reset values asynchronously, before the next clock edge; after release, req_n=3 yields 0x00000006 normally.
